// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle MIPS-subset controller: state encodings,
// opcode/funct values, datapath select codes and small decode helpers.
package cpu_defs;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // Instructions that go through EXEC (everything legal except j, jr, jal).
    function automatic logic is_exec_instr(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE)
            return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_ADDI) || (op == OP_XORI);
    endfunction

    function automatic logic [2:0] alu_op_for(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE) begin
            if (fn == FN_SUB) return ALU_SUB;
            if (fn == FN_SLT) return ALU_SLT;
            return ALU_ADD;
        end
        if ((op == OP_BEQ) || (op == OP_BNE)) return ALU_SUB;
        if (op == OP_XORI) return ALU_XOR;
        return ALU_ADD;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles spent waiting for the data memory; expired marks the last
// cycle the controller may still accept mem_ready before declaring a bus error.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module multicycle_control
    import cpu_defs::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instruction,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 jump,
    output logic                 jump_reg,
    output logic                 branch,
    output logic                 inv_zero,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src,
    output logic [2:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 bus_error,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    state_t     state_r;
    logic [5:0] opcode_r, funct_r;
    logic [5:0] dec_op, dec_fn;
    logic       timer_expired;
    logic       unused_inputs;

    // The branch decision itself is made by the IFU, so zero is not consumed here.
    assign unused_inputs = ^{instruction[25:6], zero};
    assign dec_op = instruction[31:26];
    assign dec_fn = instruction[5:0];
    assign state  = state_r;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_r == ST_EXEC),
        .enable  ((state_r == ST_MEM) && !mem_ready),
        .expired (timer_expired)
    );

    // Outputs are gated by rst_n so strobes vanish the moment reset asserts.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        branch     = 1'b0;
        inv_zero   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            case (state_r)
                ST_FETCH: ir_write = 1'b1;
                ST_DECODE: begin
                    if (dec_op == OP_J) begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                    end else if ((dec_op == OP_RTYPE) && (dec_fn == FN_JR)) begin
                        jump_reg = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_EXEC: begin
                    alu_op  = alu_op_for(opcode_r, funct_r);
                    alu_src = (opcode_r == OP_ADDI) || (opcode_r == OP_XORI) ||
                              (opcode_r == OP_LW) || (opcode_r == OP_SW);
                    if ((opcode_r == OP_BEQ) || (opcode_r == OP_BNE)) begin
                        branch   = 1'b1;
                        inv_zero = (opcode_r == OP_BNE);
                        pc_write = 1'b1;
                    end
                end
                ST_MEM: begin
                    mem_read  = (opcode_r == OP_LW);
                    mem_write = (opcode_r == OP_SW);
                    pc_write  = (opcode_r == OP_SW) && mem_ready;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    if (opcode_r == OP_RTYPE) begin
                        reg_dst = RD_RD;
                    end else if (opcode_r == OP_LW) begin
                        mem_to_reg = M2R_MEM;
                    end else if (opcode_r == OP_JAL) begin
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC;
                        jump       = 1'b1;
                    end
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            opcode_r  <= '0;
            funct_r   <= '0;
            retired   <= '0;
            bus_error <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (pc_write)
                retired <= retired + CNT_WIDTH'(1);
            case (state_r)
                ST_FETCH: state_r <= ST_DECODE;
                ST_DECODE: begin
                    opcode_r <= dec_op;
                    funct_r  <= dec_fn;
                    if ((dec_op == OP_J) || ((dec_op == OP_RTYPE) && (dec_fn == FN_JR)))
                        state_r <= ST_FETCH;
                    else if (dec_op == OP_JAL)
                        state_r <= ST_WB;
                    else if (is_exec_instr(dec_op, dec_fn))
                        state_r <= ST_EXEC;
                    else begin
                        illegal <= 1'b1;
                        state_r <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    if ((opcode_r == OP_BEQ) || (opcode_r == OP_BNE))
                        state_r <= ST_FETCH;
                    else if ((opcode_r == OP_LW) || (opcode_r == OP_SW))
                        state_r <= ST_MEM;
                    else
                        state_r <= ST_WB;
                end
                // mem_ready wins over an expiring timer in the same cycle.
                ST_MEM: begin
                    if (mem_ready)
                        state_r <= (opcode_r == OP_LW) ? ST_WB : ST_FETCH;
                    else if (timer_expired) begin
                        bus_error <= 1'b1;
                        state_r   <= ST_HALT;
                    end
                end
                ST_WB:   state_r <= ST_FETCH;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the MIPS-subset CPU.
- Sequences the instruction fetch unit, register file, ALU and data memory through FETCH/DECODE/EXEC/MEM/WB.
- Drives the IFU's Jump, JumpReg, Branch and InvZero flags, plus a single pc_write strobe per retired instruction.
- Handles the data-memory ready handshake, illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready before bus error (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instruction  in  32  IFU instruction output; valid in the cycle after FETCH.
- zero  in  1  ALU zero flag; valid in EXEC.
- mem_ready  in  1  data memory done; sampled in MEM.
- pc_write  out  1  IFU advances PC this edge.
- ir_write  out  1  latch instruction register.
- jump  out  1  to IFU.
- jump_reg  out  1  to IFU.
- branch  out  1  to IFU.
- inv_zero  out  1  to IFU (1 for bne).
- reg_write  out  1  register file write enable.
- reg_dst  out  2  write-register select: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write-data select: 0 = ALU, 1 = memory, 2 = PC+1.
- alu_src  out  1  0 = rt, 1 = sign/zero-extended imm16.
- alu_op  out  3  0 add, 1 sub, 2 slt, 3 xor.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- state  out  3  current FSM state, for debug.
- halted  out  1  in HALT.
- bus_error  out  1  sticky, set on MEM timeout.
- illegal  out  1  sticky, set on unknown opcode/funct.
- retired  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to FETCH.
- Reset (async, rst_n low): state=FETCH, retired=0, bus_error=0, illegal=0, opcode/funct latches=0, timeout counter=0.
- Control outputs are combinational from the current state and latched fields. All are 0 outside the listed conditions and all are 0 while rst_n is low.
- Reset may assert mid-instruction, including during MEM. pc_write and memory strobes drop immediately.
- FETCH:
  - ir_write=1.
  - Next state is always DECODE (instruction memory has 1-cycle read latency).
- DECODE: latch opcode = instruction[31:26] and funct = instruction[5:0], then dispatch:
  - j (0x02): jump=1, pc_write=1 → FETCH.
  - R-type jr (op 0x00, funct 0x08): jump_reg=1, pc_write=1 → FETCH.
  - jal (0x03) → WB.
  - lw (0x23), sw (0x2B), beq (0x04), bne (0x05), addi (0x08), xori (0x0E), R-type add (0x20) / sub (0x22) / slt (0x2A) → EXEC.
  - Anything else: illegal set → HALT.
- EXEC:
  - alu_op: add/addi/lw/sw → 0; sub/beq/bne → 1; slt → 2; xori → 3.
  - alu_src=1 for addi, xori, lw, sw.
  - beq/bne: branch=1, inv_zero = (op==0x05), pc_write=1 → FETCH. The IFU applies the zero^inv_zero decision.
  - lw/sw → MEM, timeout counter cleared.
  - All others → WB.
- MEM:
  - mem_read (lw) or mem_write (sw) held high until mem_ready=1.
  - On mem_ready: lw → WB; sw asserts pc_write=1 → FETCH.
  - Otherwise the timeout counter increments. When the counter reaches MEM_TIMEOUT with mem_ready still 0: bus_error set, strobes drop next cycle → HALT.
  - mem_ready on the same cycle the timeout expires counts as success.
- WB:
  - reg_write=1 and pc_write=1 → FETCH.
  - R-type: reg_dst=1, mem_to_reg=0.
  - addi/xori: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - jal: reg_dst=2, mem_to_reg=2, jump=1.
- retired increments on every cycle with pc_write=1 and wraps modulo 2^CNT_WIDTH.
- HALT: absorbing; all strobes 0, halted=1. Exits only via reset.
- Cycles per instruction:
  - j, jr: 2.
  - beq, bne, jal: 3.
  - R-type, addi, xori: 4.
  - sw: 4 + wait cycles.
  - lw: 5 + wait cycles.

Decomposition:
- Shared package cpu_defs holds:
  - state encodings;
  - opcode and funct constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW, FN_ADD, FN_SUB, FN_SLT, FN_JR);
  - alu_op, reg_dst and mem_to_reg codes.
- One sub-module, mem_wait_timer: MEM_TIMEOUT counter with clear/enable/expired.

Test Plan:
- add (op 0x00, funct 0x20) → states 0,1,2,4,0. pc_write only in WB, reg_dst=1, alu_op=0, retired=1.
- bne with zero=0: EXEC shows branch=1, inv_zero=1, pc_write=1; next state 0. Then j 0x0000009: DECODE shows jump=1, pc_write=1; retired=2 after 5 cycles total.
- lw with mem_ready delayed 3 cycles → mem_read high 4 cycles in MEM, then WB with mem_to_reg=1, reg_write=1; 8 cycles total.
- sw with mem_ready tied 0, MEM_TIMEOUT=16 → bus_error=1 and state=5 after 16 MEM cycles. Further instructions ignored, pc_write stays 0.
- Opcode 0x3F → illegal=1, halted=1 after DECODE. rst_n low → state=0, flags cleared, retired=0.
- rst_n pulled low during MEM of lw → mem_read drops combinationally, no reg_write. After release, execution restarts in FETCH.
